// File: rtl/rv_core_pkg.sv
// Shared RV32I core types and constants for the fetch front end.
package rv_core_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_STEP = 4;

  // One buffered fetch result: the address it came from and the raw instruction word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries.
// The head is presented from a register, so it never depends combinationally on pop.
// A flush empties the queue but keeps the head register as-is; only reset clears storage.
module fetch_fifo
  import rv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  fetch_entry_t    push_entry_i,
  input  logic            pop_i,
  output logic [CntW-1:0] count_o,
  output fetch_entry_t    head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PtrW-1:0] wr_q, wr_d;
  logic [PtrW-1:0] rd_q, rd_d;
  logic [CntW-1:0] count_q, count_d;
  fetch_entry_t    head_q, head_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Next-state for storage, pointers, occupancy and the registered head view.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = push_entry_i;
        wr_d        = ptr_inc(wr_q);
      end
      if (pop_i) begin
        rd_d = ptr_inc(rd_q);
      end
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      // Reading mem_d covers a push into an empty queue becoming the head immediately.
      if (count_d != '0) begin
        head_d = mem_d[rd_d];
      end
    end
  end

  // State registers; reset also wipes the storage and the head view.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: owns the fetch PC, issues word requests to a fixed one-cycle
// instruction memory, buffers responses in a prefetch FIFO and serves decode via valid/ready.
// Execute redirects override everything else in the cycle they arrive.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_4
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;

  logic [CntW-1:0] count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic [OccW-1:0] occ;

  // Head validity comes only from registered occupancy, keeping if_ready out of if_valid.
  assign if_valid = (count != '0);
  assign pop      = if_valid & if_ready;

  // Slots already claimed once this cycle's pop retires; a new request needs one spare.
  assign occ      = OccW'(count) + OccW'(inflight_q) - OccW'(pop);
  assign imem_req = !reset && !redirect_valid && (occ < OccW'(DEPTH));

  assign imem_addr = fetch_pc_q;

  assign push       = inflight_q && !kill_q && !redirect_valid && !reset;
  assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

  // Fetch PC advance, redirect target capture and in-flight tracking.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    // No request is ever issued in a redirect cycle, so nothing is left to kill afterwards.
    kill_d     = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (imem_req) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    end
  end

  // PC and request-tracking registers; reset restarts fetch at RESET_PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fetch_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign if_instr = head.instr;
  assign if_pc    = head.pc;
  assign if_pc_4  = head.pc + XLEN'(PC_STEP);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_4       (if_pc_4)
  );

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  // Memory returns the word for the address requested in the previous cycle.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mk_instr(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check_eq({tag, ".valid"}, {31'b0, if_valid}, 32'd1);
    check_eq({tag, ".pc"}, if_pc, pc);
    check_eq({tag, ".pc_4"}, if_pc_4, pc + 32'd4);
    check_eq({tag, ".instr"}, if_instr, mk_instr(pc));
  endtask

  // Leaves the bench inside a cycle whose preceding edge sampled reset high.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned reqs;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;

    // Reset state.
    do_reset();
    settle();
    check_eq("rst.req", {31'b0, imem_req}, 32'd0);
    check_eq("rst.addr", imem_addr, 32'h0);
    check_eq("rst.valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst.instr", if_instr, 32'h0);
    check_eq("rst.pc", if_pc, 32'h0);
    check_eq("rst.pc_4", if_pc_4, 32'h4);

    // Streaming from reset release with if_ready high.
    tick(); reset = 1'b0; if_ready = 1'b1; settle();
    check_eq("R.req", {31'b0, imem_req}, 32'd1);
    check_eq("R.addr", imem_addr, 32'h0);
    tick(); settle();
    check_eq("R1.valid", {31'b0, if_valid}, 32'd0);
    check_eq("R1.addr", imem_addr, 32'h4);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      expect_head("stream", 32'(i * 4));
    end

    // Stall from reset: only two requests fit, then resume on pop credit.
    do_reset();
    tick(); reset = 1'b0; if_ready = 1'b0; settle();
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        tick(); settle();
      end
      reqs += {31'b0, imem_req};
    end
    check_eq("stall.reqs", reqs, 32'd2);
    check_eq("stall.req_low", {31'b0, imem_req}, 32'd0);
    check_eq("stall.valid", {31'b0, if_valid}, 32'd1);
    tick(); if_ready = 1'b1; settle();
    check_eq("resume.req", {31'b0, imem_req}, 32'd1);
    check_eq("resume.addr", imem_addr, 32'h8);
    expect_head("resume", 32'h0);
    for (int i = 1; i < 6; i++) begin
      tick(); settle();
      expect_head("resume", 32'(i * 4));
    end

    // Redirect to 0x103 with two entries buffered.
    do_reset();
    tick(); reset = 1'b0; if_ready = 1'b0; settle();
    repeat (3) begin
      tick(); settle();
    end
    check_eq("redir.full_valid", {31'b0, if_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; settle();
    check_eq("redir.N_req", {31'b0, imem_req}, 32'd0);
    tick(); redirect_valid = 1'b0; if_ready = 1'b1; settle();
    check_eq("redir.N1_valid", {31'b0, if_valid}, 32'd0);
    check_eq("redir.N1_req", {31'b0, imem_req}, 32'd1);
    check_eq("redir.N1_addr", imem_addr, 32'h100);
    tick(); settle();
    check_eq("redir.N2_valid", {31'b0, if_valid}, 32'd0);
    tick(); settle();
    expect_head("redir.N3", 32'h100);
    tick(); settle();
    expect_head("redir.N4", 32'h104);

    // Redirect concurrent with a pop and a returning response, then a second redirect.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0180; settle();
    check_eq("dbl.M_valid", {31'b0, if_valid}, 32'd1);
    check_eq("dbl.M_req", {31'b0, imem_req}, 32'd0);
    tick(); redirect_pc = 32'h0000_0203; settle();
    check_eq("dbl.M1_valid", {31'b0, if_valid}, 32'd0);
    check_eq("dbl.M1_req", {31'b0, imem_req}, 32'd0);
    tick(); redirect_valid = 1'b0; settle();
    check_eq("dbl.M2_valid", {31'b0, if_valid}, 32'd0);
    check_eq("dbl.M2_addr", imem_addr, 32'h200);
    tick(); settle();
    check_eq("dbl.M3_valid", {31'b0, if_valid}, 32'd0);
    tick(); settle();
    expect_head("dbl.M4", 32'h200);
    tick(); settle();
    expect_head("dbl.M5", 32'h204);

    // Redirect near the top of the address space: PC wraps to zero.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; settle();
    tick(); redirect_valid = 1'b0; settle();
    check_eq("wrap.N1_addr", imem_addr, 32'hFFFF_FFF8);
    tick(); settle();
    check_eq("wrap.N2_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); settle();
    expect_head("wrap.N3", 32'hFFFF_FFF8);
    check_eq("wrap.N3_addr", imem_addr, 32'h0);
    tick(); settle();
    expect_head("wrap.N4", 32'hFFFF_FFFC);
    check_eq("wrap.N4_pc_4", if_pc_4, 32'h0);
    tick(); settle();
    expect_head("wrap.N5", 32'h0);

    // Reset mid-stream with a full FIFO.
    tick(); if_ready = 1'b0; settle();
    tick(); settle();
    check_eq("mrst.full_valid", {31'b0, if_valid}, 32'd1);
    check_eq("mrst.full_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b1; settle();
    check_eq("mrst.req_in_reset", {31'b0, imem_req}, 32'd0);
    tick(); reset = 1'b0; if_ready = 1'b1; settle();
    check_eq("mrst.R_valid", {31'b0, if_valid}, 32'd0);
    check_eq("mrst.R_pc", if_pc, 32'h0);
    check_eq("mrst.R_req", {31'b0, imem_req}, 32'd1);
    check_eq("mrst.R_addr", imem_addr, 32'h0);
    tick(); settle();
    check_eq("mrst.R1_valid", {31'b0, if_valid}, 32'd0);
    tick(); settle();
    expect_head("mrst.R2", 32'h0);
    tick(); settle();
    expect_head("mrst.R3", 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
